// File: rtl/multiword_adder_sequencer.sv
// multiword_adder_sequencer: WORDS*N-bit add built from one shared N-bit
// ripple-carry adder, stepping one word per cycle, least significant word
// first, with the carry held in a register between words.
// Optional feature macro: ADDER_SEQ_SUB_EN adds op_sub for a - b.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid must not depend on ready. in_ready is high only in IDLE,
// out_valid only in DONE, so accept and hand-off never share a cycle.

// N-bit ripple-carry adder shared by every word of the wide operation.
module ripple_carry_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    // Bit-serial carry chain, least significant bit first.
    always_comb begin
        logic c;
        c = cin;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module multiword_adder_sequencer #(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    input  logic                 cin,
`ifdef ADDER_SEQ_SUB_EN
    input  logic                 op_sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 busy,
    output logic [1:0]           state_dbg
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [N*WORDS-1:0] opa, opb;
    logic               carry_reg;
    logic [IW-1:0]      idx;
    logic [N-1:0]       add_sum;
    logic               add_cout;
    logic               sub_sel;

`ifdef ADDER_SEQ_SUB_EN
    assign sub_sel = op_sub;
`else
    assign sub_sel = 1'b0;
`endif

    ripple_carry_adder #(.N(N)) u_rca (
        .a    (opa[int'(idx)*N +: N]),
        .b    (opb[int'(idx)*N +: N]),
        .cin  (carry_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic: accept in IDLE, step words in RUN, hold in DONE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = RUN;
            RUN:     if (idx == LAST) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, write one sum word per RUN cycle.
    // Subtraction stores ~b and seeds the carry with 1 (two's complement).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa       <= '0;
            opb       <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa       <= a;
                        opb       <= sub_sel ? ~b : b;
                        carry_reg <= sub_sel ? 1'b1 : cin;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    sum[int'(idx)*N +: N] <= add_sum;
                    carry_reg             <= add_cout;
                    if (idx == LAST) begin
                        cout <= add_cout;
                        idx  <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/multiword_adder_sequencer.md
Name: multiword_adder_sequencer

Overview:
- Performs WORDS*N-bit addition by time-sharing one N-bit ripple_carry_adder instance, one word per cycle, LSW first.
- The carry is registered between cycles.
- It is the sequencing controller that lets the existing narrow adder serve wide operands (e.g. 128-bit) without replicating adder hardware.
- Sits between a valid/ready producer and a valid/ready consumer.

Parameters:
- N, 32, width of the shared adder in bits; passed to ripple_carry_adder.
- WORDS, 4, number of N-bit words per operand; must be >= 1.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair a/b/cin is valid.
- in_ready  output  1  block can accept an operation; equals (state == IDLE).
- a  input  N*WORDS  operand A, word 0 = bits [N-1:0].
- b  input  N*WORDS  operand B.
- cin  input  1  carry into word 0.
- out_valid  output  1  sum/cout hold a completed result.
- out_ready  input  1  consumer accepts result.
- sum  output  N*WORDS  registered result.
- cout  output  1  carry out of the most significant word.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, out_valid = 0, sum = 0, cout = 0, busy = 0, word index = 0, carry register = 0, operand registers = 0.
  - in_ready follows state (1), but inputs are ignored while rst_n is low.
- Clock-less effect: deasserting rst_n mid-operation discards the operation completely; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: capture a, b into operand registers, carry_reg <= cin, idx <= 0, go to RUN.
  - out_valid is 0 in IDLE.
- RUN:
  - The adder inputs are operand word idx of a, operand word idx of b, and carry_reg.
  - Each edge: sum word idx <= adder sum, carry_reg <= adder cout, idx <= idx + 1.
  - On the edge where idx == WORDS-1: cout <= adder cout, state <= DONE, idx <= 0.
  - in_ready = 0.
- DONE:
  - out_valid = 1; sum and cout are held stable.
  - On an edge with out_ready = 1: go to IDLE. out_valid drops, but the sum/cout registers keep their last value.
  - in_ready = 0 in DONE, so a new operation cannot be accepted in the same cycle as result hand-off.
- Latency and throughput:
  - Accept edge at t0; out_valid is high after edge t0+WORDS, i.e. exactly WORDS cycles.
  - With out_ready held high, back-to-back throughput is one operation per WORDS+2 cycles.
- Width rules:
  - idx width = max(1, $clog2(WORDS)).
  - The result is modulo 2^(N*WORDS); the carry beyond the top word is reported only on cout.
  - WORDS = 1: RUN lasts a single cycle.
- Input changes: a/b/cin changing after acceptance have no effect (operands are registered).
- No internal overflow/signed flag.

Optional Feature:
- Macro: ADDER_SEQ_SUB_EN.
- When defined:
  - Adds input port op_sub (1 bit), sampled with a/b on acceptance.
  - When op_sub = 1: every word of b is bit-inverted before entering the adder, and carry_reg is initialised to 1 (cin ignored).
  - sum = a - b modulo 2^(N*WORDS); cout = 1 means no borrow.
- When undefined: op_sub does not exist and behaviour is add-only as above.

Test Plan (N=32, WORDS=4):
- Basic add: a=0x3, b=0xA, cin=0 -> sum=0xD, cout=0; out_valid rises exactly 4 cycles after the accept edge; in_ready=0 and busy=1 throughout.
- Full ripple: a = 128'hFFFF...FFFF, b=1, cin=0 -> sum=0, cout=1 (carry propagates through all 4 words).
- Pattern: a = 128'hAAAA...AAAA, b = 128'h5555...5555, cin=1 -> sum=0, cout=1; the same operands with cin=0 -> sum = all ones, cout=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE with in_valid=1 and new operands -> sum/cout unchanged, in_ready=0, new operands not accepted; raise out_ready -> IDLE next edge, accept on the following edge.
- Reset mid-RUN: assert rst_n=0 while idx=2 -> out_valid/sum/cout/busy go to 0 immediately, without waiting for a clock edge. After release, a=0x1234_5678, b=0x1 -> sum=0x1234_5679.
- With ADDER_SEQ_SUB_EN: op_sub=1, a=5, b=7 -> sum = 128'hFFFF...FFFE, cout=0; then a=7, b=5 -> sum=2, cout=1.
